// File: rtl/mem_port_arbiter_if.sv
// Shared SRAM/MMU port bundle: IF and MEM requesters on one side,
// the MMU issue/complete handshake on the other.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rw;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        sram_req;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic        sram_rw;
  logic        sram_done;
  logic [31:0] sram_rdata;
  logic        bus_err;
  logic        busy;
  logic        owner;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_addr, mem_wdata, mem_be, mem_rw,
    input  sram_done, sram_rdata,
    output if_ack, if_rdata, mem_ack, mem_rdata,
    output sram_req, sram_addr, sram_wdata, sram_be, sram_rw,
    output bus_err, busy, owner
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_addr, mem_wdata, mem_be, mem_rw,
    output sram_done, sram_rdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata,
    input  sram_req, sram_addr, sram_wdata, sram_be, sram_rw,
    input  bus_err, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM accesses onto one SRAM/MMU port.
// MEM has priority; IF gets a guaranteed slot after a contested streak.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 16
) (
  input logic               soc_clk,
  input logic               soc_reset_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic       any_req;
  logic       pick_mem;
  logic       fin;
  logic       tout;

  always_comb begin
    any_req  = bus.if_req | bus.mem_req;
    pick_mem = bus.mem_req
             & ~(bus.if_req & (streak == SLIM));
    tout     = ~bus.sram_done;
    unique case (state)
      ISSUE:   fin = bus.sram_done;
      WAIT:    fin = bus.sram_done | (tcnt == TLIM);
      default: fin = 1'b0;
    endcase
  end

  always_ff @(posedge soc_clk or negedge soc_reset_n) begin
    if (!soc_reset_n) begin
      state          <= IDLE;
      streak         <= '0;
      tcnt           <= '0;
      bus.sram_req   <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
      bus.sram_be    <= '0;
      bus.sram_rw    <= 1'b0;
      bus.if_ack     <= 1'b0;
      bus.if_rdata   <= '0;
      bus.mem_ack    <= 1'b0;
      bus.mem_rdata  <= '0;
      bus.bus_err    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.owner      <= 1'b0;
    end else begin
      bus.sram_req <= 1'b0;
      bus.if_ack   <= 1'b0;
      bus.mem_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state        <= ISSUE;
            bus.busy     <= 1'b1;
            bus.sram_req <= 1'b1;
            tcnt         <= '0;
            if (pick_mem) begin
              bus.owner      <= 1'b1;
              bus.sram_addr  <= bus.mem_addr;
              bus.sram_wdata <= bus.mem_wdata;
              bus.sram_be    <= bus.mem_be;
              bus.sram_rw    <= bus.mem_rw;
              if (!bus.if_req)        streak <= '0;
              else if (streak != SLIM) streak <= streak + 4'd1;
            end else begin
              bus.owner      <= 1'b0;
              bus.sram_addr  <= bus.if_addr;
              bus.sram_wdata <= '0;
              bus.sram_be    <= 4'hF;
              bus.sram_rw    <= 1'b0;
              streak         <= '0;
            end
          end
        end
        ISSUE, WAIT: begin
          if (fin) begin
            state       <= RESP;
            bus.bus_err <= tout;
            // timeouts and writes return zero data
            if (bus.owner) begin
              bus.mem_ack   <= 1'b1;
              bus.mem_rdata <= (tout | bus.sram_rw) ? '0
                                                    : bus.sram_rdata;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= tout ? '0 : bus.sram_rdata;
            end
          end else if (state == ISSUE) begin
            state <= WAIT;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RESP: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.bus_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: a responder models the MMU,
// acks are matched in order against expectations queued at request time.
module tb_mem_port_arbiter;
  typedef struct packed {
    logic        is_mem;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic soc_clk;
  logic soc_reset_n;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(3),
    .TIMEOUT(16)
  ) dut (
    .soc_clk(soc_clk),
    .soc_reset_n(soc_reset_n),
    .bus(bus)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  int          vectors;
  int          miscompares;
  int          dly;
  logic [31:0] resp_data;
  int          spur_req;
  int          spur_ack;
  exp_t        exp_q[$];

  // MMU model: done after dly WAIT cycles (never if dly < 0)
  initial begin
    spur_ack = 0;
    bus.sram_done = 1'b0;
    bus.sram_rdata = '0;
    forever begin
      @(negedge soc_clk);
      bus.sram_done = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        bus.sram_done = 1'b1;
        bus.sram_rdata = 32'hFFFF_0000;
      end else if (bus.sram_req && dly >= 0) begin
        repeat (dly) @(negedge soc_clk);
        bus.sram_done = 1'b1;
        bus.sram_rdata = resp_data;
      end
    end
  end

  task automatic wait_ack(input logic is_mem, input string tag);
    int n;
    n = 0;
    while (!(is_mem ? bus.mem_ack : bus.if_ack) && n < 60) begin
      @(negedge soc_clk);
      n++;
    end
    vectors++;
    if (n >= 60) begin
      miscompares++;
      $display("FAIL %s_ack_timeout waited=%0d required<60", tag, n);
    end
  endtask

  task automatic test_reset();
    soc_reset_n = 1'b0;
    repeat (2) @(negedge soc_clk);
    vectors++;
    if ({bus.sram_req, bus.sram_rw, bus.if_ack, bus.mem_ack,
         bus.bus_err, bus.busy, bus.owner} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b required=0",
        {bus.sram_req, bus.sram_rw, bus.if_ack, bus.mem_ack,
         bus.bus_err, bus.busy, bus.owner});
    end
    vectors++;
    if ({bus.sram_addr, bus.sram_wdata, bus.sram_be} !== 68'b0) begin
      miscompares++;
      $display("FAIL reset_sram got=%h/%h/%h required=0",
        bus.sram_addr, bus.sram_wdata, bus.sram_be);
    end
    vectors++;
    if ({bus.if_rdata, bus.mem_rdata} !== 64'b0) begin
      miscompares++;
      $display("FAIL reset_rdata got=%h/%h required=0",
        bus.if_rdata, bus.mem_rdata);
    end
    soc_reset_n = 1'b1;
    @(negedge soc_clk);
  endtask

  task automatic test_if_read();
    dly = 0;
    resp_data = 32'h00A0_0093;
    bus.if_addr = 32'h0000_0040;
    bus.if_req = 1'b1;
    exp_q.push_back('{1'b0, 32'h00A0_0093, 1'b0});
    @(negedge soc_clk);
    vectors++;
    if ({bus.sram_req, bus.sram_be, bus.sram_rw, bus.owner,
         bus.sram_addr} !== {1'b1, 4'hF, 1'b0, 1'b0, 32'h40}) begin
      miscompares++;
      $display("FAIL if_issue got req=%b be=%h rw=%b own=%b a=%h required 1/f/0/0/40",
        bus.sram_req, bus.sram_be, bus.sram_rw, bus.owner, bus.sram_addr);
    end
    @(negedge soc_clk);
    vectors++;
    if ({bus.if_ack, bus.bus_err, bus.if_rdata} !==
        {1'b1, 1'b0, 32'h00A0_0093}) begin
      miscompares++;
      $display("FAIL if_latency got ack=%b err=%b d=%h required 1/0/00a00093",
        bus.if_ack, bus.bus_err, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge soc_clk);
    vectors++;
    if ({bus.if_ack, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL if_done got ack=%b busy=%b required 0/0",
        bus.if_ack, bus.busy);
    end
  endtask

  task automatic test_mem_write();
    dly = 5;
    resp_data = 32'h7777_7777;
    bus.mem_addr = 32'h0000_0100;
    bus.mem_be = 4'b0011;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_rw = 1'b1;
    bus.mem_req = 1'b1;
    exp_q.push_back('{1'b1, 32'h0, 1'b0});
    @(negedge soc_clk);
    vectors++;
    if ({bus.sram_addr, bus.sram_wdata, bus.sram_be, bus.sram_rw,
         bus.owner} !== {32'h100, 32'hDEAD_BEEF, 4'b0011, 2'b11}) begin
      miscompares++;
      $display("FAIL mw_regs got a=%h d=%h be=%h rw=%b own=%b required 100/deadbeef/3/1/1",
        bus.sram_addr, bus.sram_wdata, bus.sram_be, bus.sram_rw, bus.owner);
    end
    wait_ack(1'b1, "mw");
    bus.mem_req = 1'b0;
    @(negedge soc_clk);
    vectors++;
    if (bus.mem_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL mw_pulse got mem_ack=%b required 0", bus.mem_ack);
    end
  endtask

  task automatic test_starvation();
    int n;
    logic want;
    dly = 0;
    resp_data = 32'h1234_5678;
    bus.mem_addr = 32'h0000_0300;
    bus.mem_rw = 1'b0;
    bus.mem_be = 4'hF;
    bus.if_addr = 32'h0000_0400;
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{(i % 4) != 3, 32'h1234_5678, 1'b0});
    bus.if_req = 1'b1;
    bus.mem_req = 1'b1;
    for (int g = 0; g < 8; g++) begin
      want = (g % 4) != 3;
      n = 0;
      @(negedge soc_clk);
      while (!bus.sram_req && n < 20) begin
        @(negedge soc_clk);
        n++;
      end
      vectors++;
      if (bus.sram_req !== 1'b1 || bus.owner !== want) begin
        miscompares++;
        $display("FAIL starve_grant%0d got req=%b owner=%b required 1/%b",
          g, bus.sram_req, bus.owner, want);
      end
    end
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    repeat (4) @(negedge soc_clk);
  endtask

  task automatic test_timeout();
    int n;
    dly = -1;
    bus.if_addr = 32'h0000_0800;
    bus.if_req = 1'b1;
    exp_q.push_back('{1'b0, 32'h0, 1'b1});
    @(negedge soc_clk);
    n = 0;
    while (!bus.if_ack && n < 40) begin
      @(negedge soc_clk);
      n++;
    end
    vectors++;
    if (n != 17 || bus.bus_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_len got cycles=%0d err=%b required 17/1",
        n, bus.bus_err);
    end
    bus.if_req = 1'b0;
    @(negedge soc_clk);
    dly = 0;
    resp_data = 32'h55AA_55AA;
    bus.mem_addr = 32'h0000_0500;
    bus.mem_rw = 1'b0;
    bus.mem_req = 1'b1;
    exp_q.push_back('{1'b1, 32'h55AA_55AA, 1'b0});
    wait_ack(1'b1, "after_to");
    vectors++;
    if (bus.bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL after_to_err got=%b required 0", bus.bus_err);
    end
    bus.mem_req = 1'b0;
    @(negedge soc_clk);
  endtask

  task automatic test_reset_mid();
    dly = -1;
    bus.mem_addr = 32'h0000_0600;
    bus.mem_rw = 1'b1;
    bus.mem_req = 1'b1;
    repeat (4) @(negedge soc_clk);
    soc_reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.sram_req, bus.owner, bus.mem_ack, bus.if_ack,
         bus.sram_addr, bus.mem_rdata, bus.if_rdata} !== 101'b0) begin
      miscompares++;
      $display("FAIL midrst_clear got busy=%b own=%b a=%h required 0",
        bus.busy, bus.owner, bus.sram_addr);
    end
    bus.mem_req = 1'b0;
    @(negedge soc_clk);
    soc_reset_n = 1'b1;
    spur_req++;
    for (int i = 0; i < 5; i++) begin
      @(negedge soc_clk);
      vectors++;
      if ({bus.busy, bus.sram_req, bus.if_ack, bus.mem_ack} !== 4'b0) begin
        miscompares++;
        $display("FAIL midrst_stale%0d got busy=%b req=%b acks=%b%b required 0",
          i, bus.busy, bus.sram_req, bus.if_ack, bus.mem_ack);
      end
    end
  endtask

  task automatic test_spurious();
    int n;
    spur_req++;
    repeat (2) @(negedge soc_clk);
    vectors++;
    if ({bus.busy, bus.sram_req, bus.if_ack, bus.mem_ack} !== 4'b0) begin
      miscompares++;
      $display("FAIL spur_idle got busy=%b req=%b required 0",
        bus.busy, bus.sram_req);
    end
    dly = 4;
    resp_data = 32'hCAFE_F00D;
    bus.mem_addr = 32'h0000_0200;
    bus.mem_rw = 1'b0;
    bus.mem_req = 1'b1;
    exp_q.push_back('{1'b1, 32'hCAFE_F00D, 1'b0});
    @(negedge soc_clk);
    @(negedge soc_clk);
    bus.mem_addr = 32'h0000_BAD0;
    bus.mem_wdata = 32'h0BAD_0BAD;
    n = 0;
    while (!bus.mem_ack && n < 40) begin
      vectors++;
      if (bus.sram_addr !== 32'h200) begin
        miscompares++;
        $display("FAIL spur_addr_hold got=%h required 200", bus.sram_addr);
      end
      @(negedge soc_clk);
      n++;
    end
    wait_ack(1'b1, "spur");
    bus.mem_req = 1'b0;
    repeat (2) @(negedge soc_clk);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] rd;
    vectors = 0;
    miscompares = 0;
    dly = -1;
    resp_data = '0;
    spur_req = 0;
    soc_reset_n = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.mem_req = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.mem_be = '0;
    bus.mem_rw = 1'b0;
    fork
      forever begin
        @(negedge soc_clk);
        if (bus.if_ack && bus.mem_ack) begin
          vectors++;
          miscompares++;
          $display("FAIL ack_excl got both acks required one");
        end else if (bus.if_ack || bus.mem_ack) begin
          vectors++;
          rd = bus.mem_ack ? bus.mem_rdata : bus.if_rdata;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected got mem_ack=%b if_ack=%b required none",
              bus.mem_ack, bus.if_ack);
          end else begin
            e = exp_q.pop_front();
            if ({bus.mem_ack, rd, bus.bus_err} !== {e.is_mem, e.rdata, e.err}) begin
              miscompares++;
              $display("FAIL sb_ack got mem=%b d=%h err=%b required mem=%b d=%h err=%b",
                bus.mem_ack, rd, bus.bus_err, e.is_mem, e.rdata, e.err);
            end
          end
        end
      end
    join_none
    test_reset();
    test_if_read();
    test_mem_write();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_spurious();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got pending=%0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single SRAM/MMU access port between two requesters: instruction fetch (IF, read-only) and the memory stage (MEM, read/write with byte enables).
- Sits between the CU pipeline stages and the MMU.
- Serialises one transaction at a time: arbitrate → issue → wait for completion → acknowledge.
- Fixed priority MEM > IF, with a starvation guard for IF and a completion timeout.

Parameters:
- STARVE_LIMIT, 3, consecutive contested MEM grants after which IF wins the next contested arbitration (1..15).
- TIMEOUT, 16, max cycles in WAIT without sram_done before the transaction is aborted with an error (2..255).

Ports:
- soc_clk  in  1  system clock, all state on rising edge.
- soc_reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF request; held high until if_ack.
- if_addr  in  32  IF read address.
- if_ack  out  1  one-cycle pulse; if_rdata/bus_err valid this cycle.
- if_rdata  out  32  fetched instruction word.
- mem_req  in  1  MEM request; held high until mem_ack.
- mem_addr  in  32  MEM address.
- mem_wdata  in  32  MEM write data.
- mem_be  in  4  MEM byte enables (bits_to_access).
- mem_rw  in  1  0 = read, 1 = write.
- mem_ack  out  1  one-cycle pulse; mem_rdata/bus_err valid this cycle.
- mem_rdata  out  32  MEM read data (0 for writes).
- sram_req  out  1  one-cycle issue strobe to MMU.
- sram_addr  out  32  registered address.
- sram_wdata  out  32  registered write data.
- sram_be  out  4  registered byte enables (4'b1111 for IF).
- sram_rw  out  1  registered direction (0 for IF).
- sram_done  in  1  MMU completion strobe.
- sram_rdata  in  32  MMU read data, valid with sram_done.
- bus_err  out  1  high with ack if the transaction timed out.
- busy  out  1  high in every state except IDLE.
- owner  out  1  current/last grant: 0 = IF, 1 = MEM.

Behaviour:
- Reset (async, soc_reset_n = 0):
  - State IDLE; all outputs 0, including the sram_* registers, acks, rdata, bus_err, busy and owner.
  - Streak and timeout counters cleared.
  - Reset mid-transaction abandons it silently: no ack is generated, and any later sram_done is ignored.
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: at a clock edge with any request high:
  - Grant per priority.
  - Latch addr, wdata, be and rw of the winner into the sram_* registers; set owner.
  - Go to ISSUE.
- ISSUE: sram_req = 1 for exactly this one cycle.
  - sram_done high in this cycle: capture sram_rdata, go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - sram_done high: capture sram_rdata, go to RESP.
  - Counter reaches TIMEOUT without done: go to RESP with error set and rdata forced to 0.
- RESP:
  - Winner's ack = 1 for one cycle, with rdata and bus_err.
  - For MEM writes, mem_rdata = 0.
  - Go to IDLE.
  - A request seen in IDLE on the next edge is a new transaction. Requesters deassert in the cycle after ack or issue back-to-back.
- sram_done outside ISSUE/WAIT is ignored.
- Minimum latency: req high at edge k → ISSUE in cycle k+1 → RESP (ack) in cycle k+2 when done arrives in ISSUE.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- Acks are mutually exclusive; the non-owner's rdata output holds its previous value.
- Arbitration:
  - Only one requester high: that one wins.
  - Both high: MEM wins unless streak == STARVE_LIMIT, in which case IF wins.
- Streak counter:
  - Increments on a MEM grant while if_req is also high.
  - Clears on any IF grant, or on a MEM grant with if_req low.
  - Saturates at STARVE_LIMIT.
- Request inputs are sampled only in IDLE. Changes to addr/data during ISSUE/WAIT/RESP have no effect on the issued transaction.

Test Plan:
- Single IF read, sram_done in ISSUE, sram_rdata = 32'h00A00093 → if_ack in cycle k+2, if_rdata = 32'h00A00093, sram_be = 4'hF, sram_rw = 0, bus_err = 0.
- MEM write addr 32'h100, be 4'b0011, wdata 32'hDEADBEEF, done after 5 WAIT cycles → sram_* registers match the inputs; mem_ack 1 cycle; mem_rdata = 0.
- Both requesting continuously, STARVE_LIMIT = 3 → grant order MEM, MEM, MEM, IF, MEM, MEM, MEM, IF; owner toggles accordingly.
- sram_done never asserted, TIMEOUT = 16 → ack after 16 WAIT cycles with bus_err = 1 and rdata = 0; FSM returns to IDLE and next request proceeds normally.
- soc_reset_n pulsed low during WAIT, stale sram_done afterwards → no ack, all outputs 0, busy = 0, stale done ignored.
- Spurious sram_done in IDLE, plus mem_addr changed during WAIT → no state change from the spurious done; issued sram_addr keeps its original value.
